// File: rtl/u_rx_fifo_pkg.sv
// Shared UART receive-path constants and types, imported by u_rx_qual and u_rx_fifo.
package u_rx_fifo_pkg;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int WORD_LEN = 8;

  // Default receive buffer geometry and ready-low qualification length
  localparam int RX_DEPTH          = 16;
  localparam int RX_MIN_LOW_CYCLES = 32;

  typedef enum logic [2:0] {
    r_START,
    r_CENTER,
    r_WAIT,
    r_SAMPLE,
    r_STOP
  } rec_state_e;

  // Bits needed to hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/u_rx_fifo_qual.sv
// Turns u_rec's ready level into a single-cycle push when a rising edge follows
// a long enough low period; short lows (false starts, post-reset rise) are ignored.
module u_rx_qual
  import u_rx_fifo_pkg::*;
#(
  parameter int MIN_LOW_CYCLES = RX_MIN_LOW_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic rec_readyH,
  output logic pushH
);

  localparam int CNT_W = cnt_width(MIN_LOW_CYCLES);
  localparam logic [CNT_W-1:0] LOW_MAX = CNT_W'(MIN_LOW_CYCLES);

  logic             prev_q;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (rec_readyH == HI)
      low_cnt_d = '0;
    else if (low_cnt_q != LOW_MAX)
      low_cnt_d = low_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      prev_q    <= HI;
      low_cnt_q <= '0;
    end else begin
      prev_q    <= rec_readyH;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign pushH = (prev_q == LO) && (rec_readyH == HI) && (low_cnt_q == LOW_MAX);

endmodule

// File: rtl/u_rx_fifo.sv
// First-word-fall-through receive FIFO behind u_rec with a sticky overrun flag
// for bytes that arrive while the buffer is full and not being drained.
module u_rx_fifo
  import u_rx_fifo_pkg::*;
#(
  parameter  int DEPTH          = RX_DEPTH,
  parameter  int MIN_LOW_CYCLES = RX_MIN_LOW_CYCLES,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic [WORD_LEN-1:0] rec_dataH,
  input  logic                rec_readyH,
  input  logic                rd_enH,
  output logic [WORD_LEN-1:0] rd_dataH,
  output logic                emptyH,
  output logic                fullH,
  output logic [ADDR_W:0]     countH,
  output logic                overrunH,
  input  logic                clr_overrunH
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WORD_LEN-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic push, pop, wr, drop;

  u_rx_qual #(
    .MIN_LOW_CYCLES (MIN_LOW_CYCLES)
  ) u_qual (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .rec_readyH (rec_readyH),
    .pushH      (push)
  );

  assign emptyH = (count_q == '0);
  assign fullH  = (count_q == FULL_CNT);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign pop  = rd_enH & ~emptyH;
  assign wr   = push & (~fullH | pop);
  assign drop = push & fullH & ~pop;

  always_comb begin
    wr_ptr_d  = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set has priority over a coincident clear
    overrun_d = drop ? 1'b1 : (clr_overrunH ? 1'b0 : overrun_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible once count says they were written.
  always_ff @(posedge sys_clk) begin
    if (wr)
      mem[wr_ptr_q] <= rec_dataH;
  end

  assign rd_dataH = emptyH ? '0 : mem[rd_ptr_q];
  assign countH   = count_q;
  assign overrunH = overrun_q;

endmodule

// File: tb/tb_u_rx_fifo.sv
// Scoreboard bench for u_rx_fifo: qualified bytes are queued as they are sent
// and compared against rd_dataH as the bench pops them.
module tb_u_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int MIN_LOW = 32;

  logic       sys_clk = 1'b0;
  logic       sys_rst_l;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       rd_enH;
  logic [7:0] rd_dataH;
  logic       emptyH;
  logic       fullH;
  logic [4:0] countH;
  logic       overrunH;
  logic       clr_overrunH;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  bit         ovr_model = 1'b0;

  u_rx_fifo #(
    .DEPTH          (DEPTH),
    .MIN_LOW_CYCLES (MIN_LOW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_l    (sys_rst_l),
    .rec_dataH    (rec_dataH),
    .rec_readyH   (rec_readyH),
    .rd_enH       (rd_enH),
    .rd_dataH     (rd_dataH),
    .emptyH       (emptyH),
    .fullH        (fullH),
    .countH       (countH),
    .overrunH     (overrunH),
    .clr_overrunH (clr_overrunH)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(countH), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(emptyH), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(fullH),  32'(sb.size() == DEPTH));
    chk({tag, ".ovr"},   32'(overrunH), 32'(ovr_model));
    if (sb.size() == 0) chk({tag, ".rd0"}, 32'(rd_dataH), 32'h0);
  endtask

  // Hold ready low for low_cycles edges, then raise it with optional pop/clear
  task automatic send_byte(input logic [7:0] d, input int low_cycles,
                           input bit pop, input bit clr, input string tag);
    bit popping, full_pre, qualified;
    rec_dataH  = d;
    rec_readyH = 1'b0;
    repeat (low_cycles) step();
    rec_readyH   = 1'b1;
    rd_enH       = pop;
    clr_overrunH = clr;
    popping   = pop && (sb.size() > 0);
    full_pre  = (sb.size() == DEPTH);
    qualified = (low_cycles >= MIN_LOW);
    if (popping) chk({tag, ".head"}, 32'(rd_dataH), 32'(sb[0]));
    step();
    rd_enH       = 1'b0;
    clr_overrunH = 1'b0;
    if (popping) void'(sb.pop_front());
    if (qualified && (!full_pre || popping)) sb.push_back(d);
    if (qualified && full_pre && !popping) ovr_model = 1'b1;
    else if (clr) ovr_model = 1'b0;
    check_state(tag);
  endtask

  task automatic pop_one(input string tag);
    bit had;
    had = (sb.size() > 0);
    if (had) chk({tag, ".data"}, 32'(rd_dataH), 32'(sb[0]));
    rd_enH = 1'b1;
    step();
    rd_enH = 1'b0;
    if (had) void'(sb.pop_front());
    check_state(tag);
  endtask

  task automatic clear_ovr(input string tag);
    clr_overrunH = 1'b1;
    step();
    clr_overrunH = 1'b0;
    ovr_model    = 1'b0;
    check_state(tag);
  endtask

  initial begin
    sys_rst_l    = 1'b0;
    rec_readyH   = 1'b0;
    rec_dataH    = 8'h00;
    rd_enH       = 1'b0;
    clr_overrunH = 1'b0;
    repeat (3) step();
    check_state("reset");

    // Post-reset ready rise after a single low cycle must not push
    sys_rst_l = 1'b1;
    step();
    rec_readyH = 1'b1;
    repeat (4) step();
    check_state("post_rst");

    // Long reception, then drain
    send_byte(8'hA5, 150, 1'b0, 1'b0, "rx_a5");
    chk("rx_a5.rd", 32'(rd_dataH), 32'hA5);
    pop_one("pop_a5");

    // False start, and a read strobe on an empty FIFO
    send_byte(8'h5A, 6, 1'b0, 1'b0, "false_start");
    pop_one("pop_empty");

    // Fill, overrun, drain in order, clear
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), MIN_LOW, 1'b0, 1'b0, "fill");
    send_byte(8'hFF, MIN_LOW + 1, 1'b0, 1'b0, "overrun");
    for (int i = 0; i < DEPTH; i++) pop_one("drain");
    clear_ovr("clr");

    // Full FIFO with a pop coinciding with a qualified rise
    for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), MIN_LOW, 1'b0, 1'b0, "fill2");
    send_byte(8'hEE, 40, 1'b1, 1'b0, "push_pop_full");
    for (int i = 0; i < DEPTH; i++) pop_one("drain2");

    // Wrap the pointers repeatedly with interleaved push/pop
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < DEPTH; i++)
        send_byte(8'($urandom_range(0, 255)), MIN_LOW, 1'b0, 1'b0, "wfill");
      for (int i = 0; i < 8; i++)
        send_byte(8'($urandom_range(0, 255)), MIN_LOW, 1'b1, 1'b0, "wpp");
      for (int i = 0; i < 5; i++) pop_one("wpop");
      for (int i = 0; i < 3; i++)
        send_byte(8'($urandom_range(0, 255)), MIN_LOW, 1'b1, 1'b0, "wpp2");
      while (sb.size() > 0) pop_one("wdrain");
    end

    // Clear coincident with an overrun: set wins
    for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i), MIN_LOW, 1'b0, 1'b0, "fill3");
    send_byte(8'h77, MIN_LOW, 1'b0, 1'b1, "set_wins");
    chk("set_wins.flag", 32'(overrunH), 32'h1);
    clear_ovr("clr2");
    while (sb.size() > 0) pop_one("drain3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u_rx_fifo.md
Name: u_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver (u_rec). It turns the receiver's level-style ready output into qualified byte-arrival events. Accepted bytes are pushed into a DEPTH-entry first-word-fall-through FIFO. The host drains the FIFO with a single-cycle read strobe, and a sticky overrun flag reports bytes lost while the FIFO was full.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
MIN_LOW_CYCLES, 32, minimum consecutive cycles rec_readyH must be low before its rising edge counts as a byte; rejects false starts and the post-reset rise.
ADDR_W, log2(DEPTH), derived localparam; pointer width.

Ports:
sys_clk  in  1  system clock, all logic rising-edge.
sys_rst_l  in  1  asynchronous, active-low reset.
rec_dataH  in  8  received byte from u_rec; stable while rec_readyH is high.
rec_readyH  in  1  u_rec ready level: low during reception, high when idle. A qualified rising edge marks a new byte.
rd_enH  in  1  pop strobe; honoured only when emptyH=0.
rd_dataH  out  8  head entry (FWFT); 8'h00 when emptyH=1.
emptyH  out  1  FIFO empty.
fullH  out  1  FIFO holds DEPTH entries.
countH  out  ADDR_W+1  current occupancy, 0..DEPTH.
overrunH  out  1  sticky: a qualified byte was dropped.
clr_overrunH  in  1  synchronous clear of overrunH.

Behaviour:
- Reset values:
  - All pointers, countH and overrunH are 0; emptyH=1, fullH=0, rd_dataH=8'h00.
  - The previous-ready register resets to 1; low_cnt resets to 0.
- Qualifier:
  - low_cnt counts cycles with rec_readyH=0 and saturates at MIN_LOW_CYCLES. It clears in any cycle rec_readyH=1.
  - push = (prev==0) & (rec_readyH==1) & (low_cnt==MIN_LOW_CYCLES).
  - No synchroniser is needed: rec_readyH is already registered in the sys_clk domain.
- Consequences of the qualifier:
  - The post-reset 0->1 rise of rec_readyH (low for 1 cycle) is rejected.
  - A u_rec false start (low for about 6 cycles) is rejected.
- Write:
  - On the push cycle, rec_dataH is written to mem[wr_ptr] at the clock edge and wr_ptr increments mod DEPTH.
  - countH, emptyH and fullH update on the following cycle. Push-to-emptyH-low latency is 1 clock.
- Read:
  - rd_dataH = mem[rd_ptr] combinationally whenever emptyH=0.
  - rd_enH & !emptyH advances rd_ptr mod DEPTH at the edge.
  - rd_enH while empty is ignored: no state change, no error.
- Simultaneous events:
  - Push & pop, not full, not empty: both occur; countH unchanged.
  - Push & pop when full: both occur; countH stays DEPTH; no overrun.
  - Push & rd_enH when empty: push only; countH becomes 1.
  - Push when full without pop: the byte is dropped and overrunH sets next cycle. Memory and pointers are unchanged.
  - clr_overrunH in the same cycle as an overrun event: set wins.
- Flags are derived from countH: emptyH = (countH==0), fullH = (countH==DEPTH). Pointers wrap silently.
- Reset mid-reception: state returns to reset values and buffered bytes are lost. Because low_cnt restarts at 0, a reception already in progress is accepted only if MIN_LOW_CYCLES of low remain after reset release.

Decomposition:
- Default DEPTH and MIN_LOW_CYCLES belong alongside the existing UART constants (HI/LO, WORD_LEN, r_* states) in inc.h.
- Natural sub-module: u_rx_qual, containing the prev register, low_cnt and push output. The FIFO storage stays in u_rx_fifo.

Test Plan:
1. Release reset with rec_readyH following u_rec (0 for 1 cycle, then 1) -> no push; emptyH stays 1, countH=0.
2. Drive rec_readyH low 150 cycles with rec_dataH=8'hA5, then high -> emptyH=0 one cycle after the rise; rd_dataH=8'hA5, countH=1. Pulse rd_enH -> emptyH=1, rd_dataH=8'h00.
3. Drive rec_readyH low for 6 cycles, then high (false start) -> no push; countH unchanged.
4. Push 16 bytes 8'h00..8'h0F without reading -> fullH=1, countH=16. Push a 17th byte (8'hFF) -> overrunH=1 and data stays 00..0F. Read all 16 in order, then pulse clr_overrunH -> overrunH=0.
5. Hold the FIFO full while rd_enH coincides with a qualified rise -> countH stays 16, overrunH stays 0, new byte appears last.
6. Fill to 16 and drain across wrap 3 times with interleaved single push/pop -> data order preserved; clr_overrunH coincident with an overrun leaves overrunH=1.
